// File: rtl/fifo_pkg.sv
// Shared sizing defaults for the synchronous FIFO and its storage.
package fifo_pkg;
  localparam int FIFO_WORD  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_ADDR  = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WORD register array, synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WORD  = FIFO_WORD,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int ADDR  = FIFO_ADDR
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [ADDR-1:0] waddr_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic [ADDR-1:0] raddr_i,
  output logic [WORD-1:0] rdata_o
);
  // No reset: stale contents are unreachable until rewritten.
  logic [WORD-1:0] memArray [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) memArray[waddr_i] <= wdata_i;
  end

  assign rdata_o = memArray[raddr_i];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit binary pointers and a registered read port.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WORD  = FIFO_WORD,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int ADDR  = FIFO_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ren,
  input  logic            wen,
  input  logic [WORD-1:0] w_word,
  output logic [WORD-1:0] r_word,
  output logic            full,
  output logic            empty
);
  logic [ADDR:0]   wptr_q, wptr_d;
  logic [ADDR:0]   rCounterBinary, rptr_d;
  logic [WORD-1:0] r_word_q, r_word_d;
  logic [WORD-1:0] mem_rdata;
  logic            wr_acc, rd_acc;

  // Flags come only from registered pointers, so they track the post-edge state.
  assign empty = (wptr_q == rCounterBinary);
  assign full  = (wptr_q[ADDR] != rCounterBinary[ADDR]) &&
                 (wptr_q[ADDR-1:0] == rCounterBinary[ADDR-1:0]);

  assign wr_acc = wen && !full && !rst;
  assign rd_acc = ren && !empty && !rst;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rCounterBinary;
    r_word_d = r_word_q;
    if (wr_acc) wptr_d = wptr_q + (ADDR+1)'(1);
    if (rd_acc) begin
      rptr_d   = rCounterBinary + (ADDR+1)'(1);
      r_word_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q         <= '0;
      rCounterBinary <= '0;
      r_word_q       <= '0;
    end else begin
      wptr_q         <= wptr_d;
      rCounterBinary <= rptr_d;
      r_word_q       <= r_word_d;
    end
  end

  assign r_word = r_word_q;

  fifo_mem #(
    .WORD  (WORD),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ADDR-1:0]),
    .wdata_i (w_word),
    .raddr_i (rCounterBinary[ADDR-1:0]),
    .rdata_o (mem_rdata)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed-vector bench for sync_fifo with hand-computed expectations.
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst, ren, wen;
  logic [7:0] w_word, r_word;
  logic       full, empty;

  int n_vec = 0;
  int n_bad = 0;

  sync_fifo dut (
    .clk    (clk),
    .rst    (rst),
    .ren    (ren),
    .wen    (wen),
    .w_word (w_word),
    .r_word (r_word),
    .full   (full),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wen = 1'b1; w_word = d; tick(); wen = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    ren = 1'b1; tick(); ren = 1'b0;
    chk(tag, {24'd0, r_word}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0; w_word = 8'h00;
    tick();
    rst = 1'b0;
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_rword", {24'd0, r_word}, 0);
    chk("rst_rptr", {28'd0, dut.rCounterBinary}, 0);

    // Fill 1..8, full only after the 8th edge.
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      chk("fill_full", {31'd0, full}, (i == 8) ? 1 : 0);
      chk("fill_empty", {31'd0, empty}, 0);
    end
    push(8'd9);
    chk("drop_full", {31'd0, full}, 1);
    for (int k = 0; k < 8; k++)
      chk("mem_fill", {24'd0, dut.mem.memArray[k]}, k + 1);

    // Drain, then an extra read while empty must hold r_word.
    for (int i = 1; i <= 8; i++) begin
      pop_chk("drain_data", 8'(i));
      chk("drain_empty", {31'd0, empty}, (i == 8) ? 1 : 0);
    end
    pop_chk("empty_read_hold", 8'd8);
    chk("empty_read_flag", {31'd0, empty}, 1);

    // Wrap: pointers start at 8, so this crosses the MSB toggle.
    for (int i = 1; i <= 6; i++) push(8'(i));
    for (int i = 1; i <= 4; i++) pop_chk("wrap_pre", 8'(i));
    for (int i = 7; i <= 12; i++) push(8'(i));
    chk("wrap_full", {31'd0, full}, 1);
    for (int i = 5; i <= 12; i++) pop_chk("wrap_data", 8'(i));
    chk("wrap_empty", {31'd0, empty}, 1);

    // Simultaneous while empty: write only, r_word holds.
    wen = 1'b1; ren = 1'b1; w_word = 8'h11; tick(); wen = 1'b0; ren = 1'b0;
    chk("sim_e_empty", {31'd0, empty}, 0);
    chk("sim_e_rword", {24'd0, r_word}, 8'd12);
    push(8'h22);
    push(8'h33);
    // Simultaneous with 3 stored: both accepted.
    wen = 1'b1; ren = 1'b1; w_word = 8'h44; tick(); wen = 1'b0; ren = 1'b0;
    chk("sim_3_rword", {24'd0, r_word}, 8'h11);
    chk("sim_3_empty", {31'd0, empty}, 0);
    chk("sim_3_full", {31'd0, full}, 0);
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    chk("sim_f_pre", {31'd0, full}, 1);
    // Simultaneous while full: read only, 0x99 dropped.
    wen = 1'b1; ren = 1'b1; w_word = 8'h99; tick(); wen = 1'b0; ren = 1'b0;
    chk("sim_f_rword", {24'd0, r_word}, 8'h22);
    chk("sim_f_full", {31'd0, full}, 0);
    pop_chk("sim_f_d0", 8'h33);
    pop_chk("sim_f_d1", 8'h44);
    for (int i = 0; i < 5; i++) pop_chk("sim_f_dn", 8'h50 + 8'(i));
    chk("sim_f_empty", {31'd0, empty}, 1);

    // Mid-operation reset with a write request held high.
    for (int i = 1; i <= 5; i++) push(8'(i));
    rst = 1'b1; wen = 1'b1; w_word = 8'h77; tick(); rst = 1'b0; wen = 1'b0;
    chk("mid_rst_empty", {31'd0, empty}, 1);
    chk("mid_rst_full", {31'd0, full}, 0);
    chk("mid_rst_rword", {24'd0, r_word}, 0);
    chk("mid_rst_rptr", {28'd0, dut.rCounterBinary}, 0);
    push(8'hAA);
    pop_chk("post_rst_data", 8'hAA);
    chk("post_rst_empty", {31'd0, empty}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
